// File: rtl/mkio_pkg.sv
// MKIO word encoder shared definitions: sync patterns, frame size, FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mkio_pkg;

  localparam logic [5:0] SYNC_CMD          = 6'b111000;
  localparam logic [5:0] SYNC_DATA         = 6'b000111;
  localparam int         HALFBITS_PER_WORD = 40;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // One word as presented to the transmitter: sync type plus payload
  typedef struct packed {
    logic        sync;
    logic [15:0] data;
  } word_t;

endpackage

// File: rtl/mkio_frame_build.sv
// Expands {sync, data} into the 40 half-bit Manchester-II frame, hb[39] sent first.
// Latency: combinational.
// Backpressure: none.
module mkio_frame_build
  import mkio_pkg::*;
(
  input  word_t                          word,
  output logic [HALFBITS_PER_WORD-1:0]   frame
);

  // Sync pattern, Manchester data pairs MSB first, then odd parity pair
  always_comb begin
    frame = '0;
    frame[HALFBITS_PER_WORD-1 -: 6] = word.sync ? SYNC_CMD : SYNC_DATA;
    for (int i = 0; i < 16; i++) begin
      frame[2*i+3] = word.data[i];
      frame[2*i+2] = ~word.data[i];
    end
    frame[1] = ~(^word.data);
    frame[0] = ^word.data;
  end

endmodule

// File: rtl/mkio_word_encoder.sv
// MIL-STD-1553B Manchester-II word transmitter with a one-word holding register.
// Latency: word accepted at cycle N drives its first half-bit from cycle N+1; frames abut with no gap.
// Backpressure: tx_ready low while the holding register is occupied; tx_start is ignored then.
module mkio_word_encoder
  import mkio_pkg::*;
#(
  parameter int CLK_PER_HALFBIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic        tx_sync,
  input  logic [15:0] tx_data,
  input  logic        tx_abort,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        DO1,
  output logic        DO0,
  output logic        TX_INHIBIT
);

  localparam int              DW       = $clog2(CLK_PER_HALFBIT);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_PER_HALFBIT - 1);
  localparam logic [DW-1:0]   DIV_PRE  = DW'(CLK_PER_HALFBIT - 2);
  localparam logic [5:0]      HB_LAST  = 6'(HALFBITS_PER_WORD - 1);

  logic [0:0]                          state;
  logic [DW-1:0]                       div_cnt;
  logic [5:0]                          hb_cnt;
  logic [HALFBITS_PER_WORD-2:0]        shreg;
  logic                                hold_vld;
  word_t                               hold_q;
  word_t                               build_src;
  logic [HALFBITS_PER_WORD-1:0]        build_frame;
  logic                                accept;
  logic                                hb_end;
  logic                                frame_end;
  logic                                done_next;
  logic                                load;

  // The builder sees the held word if there is one, otherwise the live inputs (bypass)
  mkio_frame_build u_frame_build (
    .word  (build_src),
    .frame (build_frame)
  );

  // Handshake, half-bit / frame boundaries and shifter load decision
  always_comb begin
    accept    = tx_start && tx_ready;
    hb_end    = (state == ST_SEND) && (div_cnt == DIV_LAST);
    frame_end = hb_end && (hb_cnt == HB_LAST);
    done_next = (state == ST_SEND) && (hb_cnt == HB_LAST) && (div_cnt == DIV_PRE);
    build_src = hold_vld ? hold_q : word_t'({tx_sync, tx_data});
    load      = ((state == ST_IDLE) && accept) || (frame_end && (hold_vld || accept));
  end

  // FSM, counters, shifter, holding register and registered line outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      hb_cnt     <= '0;
      shreg      <= '0;
      hold_vld   <= 1'b0;
      hold_q     <= '0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      DO1        <= 1'b0;
      DO0        <= 1'b0;
      TX_INHIBIT <= 1'b1;
    end else if (tx_abort) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      hb_cnt     <= '0;
      shreg      <= '0;
      hold_vld   <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      DO1        <= 1'b0;
      DO0        <= 1'b0;
      TX_INHIBIT <= 1'b1;
    end else begin
      tx_done <= done_next;
      if (load) begin
        // New frame starts next clk; hold (if it was the source) is now free
        state      <= ST_SEND;
        tx_busy    <= 1'b1;
        div_cnt    <= '0;
        hb_cnt     <= '0;
        shreg      <= build_frame[HALFBITS_PER_WORD-2:0];
        DO1        <= build_frame[HALFBITS_PER_WORD-1];
        DO0        <= ~build_frame[HALFBITS_PER_WORD-1];
        TX_INHIBIT <= 1'b0;
        hold_vld   <= 1'b0;
        tx_ready   <= 1'b1;
      end else if (frame_end) begin
        state      <= ST_IDLE;
        tx_busy    <= 1'b0;
        div_cnt    <= '0;
        hb_cnt     <= '0;
        DO1        <= 1'b0;
        DO0        <= 1'b0;
        TX_INHIBIT <= 1'b1;
      end else if (state == ST_SEND) begin
        if (accept) begin
          hold_q   <= word_t'({tx_sync, tx_data});
          hold_vld <= 1'b1;
          tx_ready <= 1'b0;
        end
        if (hb_end) begin
          div_cnt <= '0;
          hb_cnt  <= hb_cnt + 6'd1;
          DO1     <= shreg[HALFBITS_PER_WORD-2];
          DO0     <= ~shreg[HALFBITS_PER_WORD-2];
          shreg   <= {shreg[HALFBITS_PER_WORD-3:0], 1'b0};
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mkio_word_encoder.sv
// Self-checking bench for mkio_word_encoder: line log plus loopback decoder against a word-level model.
// Latency: n/a.
// Backpressure: pushes wait (bounded) on tx_ready.
module tb_mkio_word_encoder;

  localparam int CPH    = 16;
  localparam int FRAME  = 40 * CPH;
  localparam int LOGMAX = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_start;
  logic        tx_sync;
  logic [15:0] tx_data;
  logic        tx_abort;
  logic        tx_ready;
  logic        tx_busy;
  logic        tx_done;
  logic        DO1;
  logic        DO0;
  logic        TX_INHIBIT;

  int checks = 0;
  int errors = 0;

  logic do1_log [LOGMAX];
  logic do0_log [LOGMAX];
  logic inh_log [LOGMAX];
  logic done_log[LOGMAX];
  logic rdy_log [LOGMAX];
  int   log_n  = 0;
  logic log_en = 1'b0;

  mkio_word_encoder #(.CLK_PER_HALFBIT(CPH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .tx_sync    (tx_sync),
    .tx_data    (tx_data),
    .tx_abort   (tx_abort),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .DO1        (DO1),
    .DO0        (DO0),
    .TX_INHIBIT (TX_INHIBIT)
  );

  always #5 clk = ~clk;

  // Record the line once per clk, on the falling edge
  always @(negedge clk) begin
    if (log_en && log_n < LOGMAX) begin
      do1_log[log_n]  = DO1;
      do0_log[log_n]  = DO0;
      inh_log[log_n]  = TX_INHIBIT;
      done_log[log_n] = tx_done;
      rdy_log[log_n]  = tx_ready;
      log_n++;
    end
  end

  // Word-level model: sync code, MSB-first Manchester pairs, odd parity pair
  function automatic logic [39:0] ref_frame(input logic s, input logic [15:0] d);
    logic [39:0] f;
    logic [5:0]  code;
    int          ones;
    f    = '0;
    code = s ? 6'b111000 : 6'b000111;
    for (int i = 5; i >= 0; i--) f = {f[38:0], code[i]};
    ones = 0;
    for (int i = 15; i >= 0; i--) begin
      f = {f[37:0], d[i], ~d[i]};
      ones += int'(d[i]);
    end
    if (ones % 2 == 0) f = {f[37:0], 2'b10};
    else               f = {f[37:0], 2'b01};
    return f;
  endfunction

  // Mid-half-bit samples of DO1 for the frame starting at log index base
  function automatic logic [39:0] sampled_frame(input int base);
    logic [39:0] f;
    for (int h = 0; h < 40; h++) f[39-h] = do1_log[base + h*CPH + CPH/2];
    return f;
  endfunction

  // Loopback receiver: returns {ok, sync, data}
  function automatic logic [17:0] rx_decode(input logic [39:0] f);
    logic        ok;
    logic        s;
    logic [15:0] d;
    int          ones;
    ok   = (f[39:34] == 6'b111000) || (f[39:34] == 6'b000111);
    s    = (f[39:34] == 6'b111000);
    ones = 0;
    d    = '0;
    for (int i = 0; i < 16; i++) begin
      if (f[33-2*i] == f[32-2*i]) ok = 1'b0;
      d[15-i] = f[33-2*i];
      ones += int'(f[33-2*i]);
    end
    if (f[1] == f[0]) ok = 1'b0;
    ones += int'(f[1]);
    if (ones % 2 == 0) ok = 1'b0;
    return {ok, s, d};
  endfunction

  // Cycles in one frame window that differ from the expected line waveform
  function automatic int line_mismatch(input int base, input logic [39:0] exp);
    int   bad;
    logic e;
    bad = 0;
    for (int k = 0; k < FRAME; k++) begin
      e = exp[39 - k/CPH];
      if (do1_log[base+k] !== e || do0_log[base+k] !== ~e || inh_log[base+k] !== 1'b0) bad++;
    end
    return bad;
  endfunction

  function automatic int bad_drive(input int start, input int len);
    int bad;
    bad = 0;
    for (int k = start; k < start + len; k++)
      if ((do1_log[k] ^ do0_log[k]) !== 1'b1 || inh_log[k] !== 1'b0) bad++;
    return bad;
  endfunction

  function automatic int idle_bad(input int start, input int len);
    int bad;
    bad = 0;
    for (int k = start; k < start + len; k++)
      if (do1_log[k] !== 1'b0 || do0_log[k] !== 1'b0 || inh_log[k] !== 1'b1) bad++;
    return bad;
  endfunction

  function automatic int done_count(input int start, input int len);
    int n;
    n = 0;
    for (int k = start; k < start + len; k++) if (done_log[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done(input int start, input int len);
    for (int k = start; k < start + len; k++) if (done_log[k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic start_log();
    log_n  = 0;
    log_en = 1'b1;
  endtask

  // Wait (bounded) until log holds n entries; ends at posedge+1
  task automatic wait_log(input int n);
    int budget;
    budget = 0;
    while (log_n < n && budget < n + 200) begin
      @(posedge clk); #1;
      budget++;
    end
    checks++;
    if (log_n < n) begin
      $display("FAIL wait_log timeout logged=%0d required=%0d", log_n, n);
      errors++;
    end
  endtask

  // Offer a word once tx_ready is seen; acc = log index of the first clk after acceptance
  task automatic push_word(input logic s, input logic [15:0] d, output int acc);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 2*FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL push_word ready_timeout tx_ready=%0b required=1", tx_ready);
      errors++;
      acc = -1;
    end else begin
      tx_start = 1'b1; tx_sync = s; tx_data = d;
      @(posedge clk); #1;
      tx_start = 1'b0;
      acc = log_n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_start = 1'b0; tx_sync = 1'b0; tx_data = '0; tx_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (DO1 !== 1'b0)        begin $display("FAIL reset_do1 got=%0b exp=0", DO1); errors++; end
    if (DO0 !== 1'b0)        begin $display("FAIL reset_do0 got=%0b exp=0", DO0); errors++; end
    if (TX_INHIBIT !== 1'b1) begin $display("FAIL reset_inhibit got=%0b exp=1", TX_INHIBIT); errors++; end
    if (tx_busy !== 1'b0)    begin $display("FAIL reset_busy got=%0b exp=0", tx_busy); errors++; end
    if (tx_done !== 1'b0)    begin $display("FAIL reset_done got=%0b exp=0", tx_done); errors++; end
    if (tx_ready !== 1'b1)   begin $display("FAIL reset_ready got=%0b exp=1", tx_ready); errors++; end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (TX_INHIBIT !== 1'b1 || DO1 !== 1'b0) begin
      $display("FAIL post_reset_idle do1=%0b inh=%0b exp do1=0 inh=1", DO1, TX_INHIBIT); errors++;
    end
  endtask

  task automatic test_command_word();
    int          a;
    int          bad;
    int          fd;
    logic [39:0] f;
    logic [17:0] rx;
    push_word(1'b1, 16'h0867, a);
    start_log();
    wait_log(FRAME + 20);
    f   = sampled_frame(0);
    rx  = rx_decode(f);
    bad = line_mismatch(0, ref_frame(1'b1, 16'h0867));
    fd  = first_done(0, FRAME + 20);
    checks += 7;
    if (bad != 0) begin $display("FAIL cmd_line bad_cycles=%0d exp=0", bad); errors++; end
    if (f[39:34] !== 6'b111000) begin $display("FAIL cmd_sync got=%b exp=111000", f[39:34]); errors++; end
    if (f[1:0] !== 2'b10) begin $display("FAIL cmd_parity got=%b exp=10", f[1:0]); errors++; end
    if (do1_log[0] !== 1'b1 || inh_log[0] !== 1'b0) begin
      $display("FAIL cmd_latency do1=%0b inh=%0b exp do1=1 inh=0", do1_log[0], inh_log[0]); errors++;
    end
    if (fd != FRAME - 1 || done_count(0, FRAME + 20) != 1) begin
      $display("FAIL cmd_done first_at=%0d count=%0d exp at=%0d count=1", fd, done_count(0, FRAME + 20), FRAME - 1); errors++;
    end
    if (idle_bad(FRAME, 20) != 0) begin $display("FAIL cmd_idle_after bad=%0d exp=0", idle_bad(FRAME, 20)); errors++; end
    if (rx !== {1'b1, 1'b1, 16'h0867}) begin $display("FAIL cmd_loopback got=%h exp=%h", rx, {1'b1, 1'b1, 16'h0867}); errors++; end
  endtask

  task automatic test_data_word();
    int          a;
    int          bad;
    logic [39:0] f;
    push_word(1'b0, 16'h0001, a);
    start_log();
    wait_log(FRAME + 20);
    f   = sampled_frame(0);
    bad = line_mismatch(0, ref_frame(1'b0, 16'h0001));
    checks += 6;
    if (bad != 0) begin $display("FAIL data_line bad_cycles=%0d exp=0", bad); errors++; end
    if (f[39:34] !== 6'b000111) begin $display("FAIL data_sync got=%b exp=000111", f[39:34]); errors++; end
    if (do1_log[FRAME - 2*CPH + CPH/2] !== 1'b0 || do1_log[FRAME - CPH/2] !== 1'b1) begin
      $display("FAIL data_parity hb1=%0b hb0=%0b exp hb1=0 hb0=1", do1_log[FRAME - 2*CPH + CPH/2], do1_log[FRAME - CPH/2]); errors++;
    end
    if (idle_bad(FRAME, 20) != 0) begin $display("FAIL data_idle_after bad=%0d exp=0", idle_bad(FRAME, 20)); errors++; end
    if (tx_busy !== 1'b0) begin $display("FAIL data_busy_after got=%0b exp=0", tx_busy); errors++; end
    if (tx_ready !== 1'b1) begin $display("FAIL data_ready_after got=%0b exp=1", tx_ready); errors++; end
  endtask

  task automatic test_back_to_back();
    logic        s[3];
    logic [15:0] d[3];
    int          acc[3];
    int          bad;
    int          end_occ;
    logic        exp_rdy;
    s[0] = 1'b1; d[0] = 16'h0800;
    s[1] = 1'b0; d[1] = 16'hA5A5;
    s[2] = 1'b0; d[2] = 16'hFFFF;
    push_word(s[0], d[0], acc[0]);
    start_log();
    push_word(s[1], d[1], acc[1]);
    push_word(s[2], d[2], acc[2]);
    wait_log(3*FRAME + 20);
    for (int j = 0; j < 3; j++) begin
      checks += 2;
      if (line_mismatch(j*FRAME, ref_frame(s[j], d[j])) != 0) begin
        $display("FAIL b2b_line word=%0d bad_cycles=%0d exp=0", j, line_mismatch(j*FRAME, ref_frame(s[j], d[j]))); errors++;
      end
      if (rx_decode(sampled_frame(j*FRAME)) !== {1'b1, s[j], d[j]}) begin
        $display("FAIL b2b_loopback word=%0d got=%h exp=%h", j, rx_decode(sampled_frame(j*FRAME)), {1'b1, s[j], d[j]}); errors++;
      end
      checks++;
      if (done_log[(j+1)*FRAME - 1] !== 1'b1) begin
        $display("FAIL b2b_done_pos word=%0d got=%0b exp=1", j, done_log[(j+1)*FRAME - 1]); errors++;
      end
    end
    checks += 4;
    if (bad_drive(0, 3*FRAME) != 0) begin $display("FAIL b2b_continuous bad=%0d exp=0", bad_drive(0, 3*FRAME)); errors++; end
    if (done_count(0, 3*FRAME + 20) != 3) begin $display("FAIL b2b_done_count got=%0d exp=3", done_count(0, 3*FRAME + 20)); errors++; end
    if (idle_bad(3*FRAME, 20) != 0) begin $display("FAIL b2b_idle_after bad=%0d exp=0", idle_bad(3*FRAME, 20)); errors++; end
    // Hold is occupied from the clk after acceptance until its frame boundary
    bad = 0;
    for (int k = 0; k < 3*FRAME; k++) begin
      exp_rdy = 1'b1;
      for (int j = 1; j < 3; j++) begin
        end_occ = (acc[j] / FRAME + 1) * FRAME;
        if (k >= acc[j] && k < end_occ) exp_rdy = 1'b0;
      end
      if (rdy_log[k] !== exp_rdy) bad++;
    end
    if (bad != 0) begin $display("FAIL b2b_ready_profile bad_cycles=%0d exp=0", bad); errors++; end
  endtask

  task automatic test_hold_full_ignore();
    int          a;
    logic [15:0] d0;
    logic [15:0] d1;
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    push_word(1'b1, d0, a);
    start_log();
    push_word(1'b0, d1, a);
    repeat (50) begin
      tx_start = 1'b1; tx_sync = 1'b1; tx_data = ~d1;
      @(posedge clk); #1;
    end
    tx_start = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin $display("FAIL ignore_ready got=%0b exp=0", tx_ready); errors++; end
    wait_log(2*FRAME + 40);
    checks += 4;
    if (line_mismatch(0, ref_frame(1'b1, d0)) != 0) begin $display("FAIL ignore_word0 bad=%0d exp=0", line_mismatch(0, ref_frame(1'b1, d0))); errors++; end
    if (line_mismatch(FRAME, ref_frame(1'b0, d1)) != 0) begin $display("FAIL ignore_word1 bad=%0d exp=0", line_mismatch(FRAME, ref_frame(1'b0, d1))); errors++; end
    if (idle_bad(2*FRAME, 40) != 0) begin $display("FAIL ignore_idle_after bad=%0d exp=0", idle_bad(2*FRAME, 40)); errors++; end
    if (done_count(0, 2*FRAME + 40) != 2) begin $display("FAIL ignore_done_count got=%0d exp=2", done_count(0, 2*FRAME + 40)); errors++; end
  endtask

  task automatic test_reset_mid_frame();
    int          a;
    int          rel;
    logic [15:0] d;
    d = 16'($urandom);
    push_word(1'b1, d, a);
    start_log();
    wait_log(20*CPH + 3);
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (DO1 !== 1'b0 || DO0 !== 1'b0 || TX_INHIBIT !== 1'b1) begin
      $display("FAIL rst_mid_lines do1=%0b do0=%0b inh=%0b exp 0 0 1", DO1, DO0, TX_INHIBIT); errors++;
    end
    if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      $display("FAIL rst_mid_status busy=%0b ready=%0b exp 0 1", tx_busy, tx_ready); errors++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    rel = log_n;
    wait_log(rel + FRAME + 20);
    checks += 2;
    if (done_count(0, log_n) != 0) begin $display("FAIL rst_mid_no_done got=%0d exp=0", done_count(0, log_n)); errors++; end
    if (idle_bad(rel, FRAME + 20) != 0) begin $display("FAIL rst_mid_idle bad=%0d exp=0", idle_bad(rel, FRAME + 20)); errors++; end
    d = 16'($urandom);
    push_word(1'b0, d, a);
    start_log();
    wait_log(FRAME + 20);
    checks += 2;
    if (line_mismatch(0, ref_frame(1'b0, d)) != 0) begin $display("FAIL rst_resume_line bad=%0d exp=0", line_mismatch(0, ref_frame(1'b0, d))); errors++; end
    if (first_done(0, FRAME + 20) != FRAME - 1) begin $display("FAIL rst_resume_done at=%0d exp=%0d", first_done(0, FRAME + 20), FRAME - 1); errors++; end
  endtask

  task automatic test_abort();
    int a;
    int ab;
    push_word(1'b1, 16'($urandom), a);
    start_log();
    push_word(1'b0, 16'($urandom), a);
    wait_log(10*CPH + 2);
    tx_abort = 1'b1; tx_start = 1'b1; tx_sync = 1'b1; tx_data = 16'h1234;
    @(posedge clk); #1;
    tx_abort = 1'b0; tx_start = 1'b0;
    ab = log_n;
    checks += 3;
    if (DO1 !== 1'b0 || DO0 !== 1'b0 || TX_INHIBIT !== 1'b1) begin
      $display("FAIL abort_lines do1=%0b do0=%0b inh=%0b exp 0 0 1", DO1, DO0, TX_INHIBIT); errors++;
    end
    if (tx_ready !== 1'b1) begin $display("FAIL abort_ready got=%0b exp=1", tx_ready); errors++; end
    if (tx_busy !== 1'b0) begin $display("FAIL abort_busy got=%0b exp=0", tx_busy); errors++; end
    wait_log(ab + 2*FRAME);
    checks += 2;
    if (done_count(0, log_n) != 0) begin $display("FAIL abort_no_done got=%0d exp=0", done_count(0, log_n)); errors++; end
    if (idle_bad(ab, 2*FRAME) != 0) begin $display("FAIL abort_hold_flushed bad=%0d exp=0", idle_bad(ab, 2*FRAME)); errors++; end
    // Abort and start together with the hold empty: abort wins, nothing is queued
    push_word(1'b0, 16'($urandom), a);
    start_log();
    repeat (30) @(posedge clk);
    #1;
    tx_abort = 1'b1; tx_start = 1'b1; tx_sync = 1'b0; tx_data = 16'h5555;
    @(posedge clk); #1;
    tx_abort = 1'b0; tx_start = 1'b0;
    ab = log_n;
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || TX_INHIBIT !== 1'b1) begin
      $display("FAIL abort_priority ready=%0b busy=%0b inh=%0b exp 1 0 1", tx_ready, tx_busy, TX_INHIBIT); errors++;
    end
    wait_log(ab + FRAME + 20);
    checks++;
    if (idle_bad(ab, FRAME + 20) != 0) begin $display("FAIL abort_priority_idle bad=%0d exp=0", idle_bad(ab, FRAME + 20)); errors++; end
  endtask

  task automatic test_random_stream();
    logic        s[4];
    logic [15:0] d[4];
    int          a;
    for (int j = 0; j < 4; j++) begin
      s[j] = 1'($urandom_range(0, 1));
      d[j] = 16'($urandom);
    end
    push_word(s[0], d[0], a);
    start_log();
    for (int j = 1; j < 4; j++) push_word(s[j], d[j], a);
    wait_log(4*FRAME + 20);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rx_decode(sampled_frame(j*FRAME)) !== {1'b1, s[j], d[j]}) begin
        $display("FAIL rand_loopback word=%0d got=%h exp=%h", j, rx_decode(sampled_frame(j*FRAME)), {1'b1, s[j], d[j]}); errors++;
      end
    end
    checks += 2;
    if (bad_drive(0, 4*FRAME) != 0) begin $display("FAIL rand_continuous bad=%0d exp=0", bad_drive(0, 4*FRAME)); errors++; end
    if (done_count(0, 4*FRAME + 20) != 4) begin $display("FAIL rand_done_count got=%0d exp=4", done_count(0, 4*FRAME + 20)); errors++; end
  endtask

  initial begin
    test_reset();
    test_command_word();
    test_data_word();
    test_back_to_back();
    test_hold_full_ignore();
    test_reset_mid_frame();
    test_abort();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit in case a wait loop misbehaves
  initial begin
    #2000000;
    $display("FAIL watchdog time_limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
